wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_fifo.sv | 75 +++++++
 rtl/wb_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared widths and queue-entry type for the writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : Power-of-two holding queue for multdiv writeback results.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           ctrl_reset_n,
  input  logic                           push_i,
  input  wb_entry_t                      push_entry_i,
  input  logic                           pop_i,
  output wb_entry_t                      head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  C_FULL   = CNT_W'(DEPTH);

  wb_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               do_push;
  logic               do_pop;

  // Requests that would overflow or underflow are ignored.
  assign do_push = push_i && (count_q != C_FULL);
  assign do_pop  = pop_i  && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Register-file writeback arbiter, pipeline over queued multdiv.
//            Define WB_ARBITER_BYPASS_EN to add the operand forwarding ports.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0]     pipe_data,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  md_ready,
  output logic                  stall_req,
  output logic                  ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0]     data_writeReg
`ifdef WB_ARBITER_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] byp_rs_a,
  input  logic [REG_ADDR_W-1:0] byp_rs_b,
  output logic                  byp_hit_a,
  output logic                  byp_hit_b,
  output logic [DATA_W-1:0]     byp_data
`endif
);

  localparam int               CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic                  we_q,   we_d;
  logic [REG_ADDR_W-1:0] reg_q,  reg_d;
  logic [DATA_W-1:0]     data_q, data_d;

  logic                  pipe_sel;
  logic                  md_accept;
  logic                  q_push;
  logic                  q_pop;
  wb_entry_t             q_in;
  wb_entry_t             q_head;
  logic [CNT_W-1:0]      q_count;

  // Readiness looks only at the registered count, so a full queue refuses
  // new results even in a cycle where it is draining.
  assign md_ready  = (q_count != C_FULL);
  assign stall_req = (q_count == C_FULL);

  assign pipe_sel  = pipe_valid && (pipe_rd != '0);
  assign md_accept = md_valid && md_ready;
  assign q_push    = md_accept && (md_rd != '0);
  assign q_pop     = !pipe_sel && (q_count != '0);

  assign q_in.rd   = md_rd;
  assign q_in.data = md_data;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .push_i       (q_push),
    .push_entry_i (q_in),
    .pop_i        (q_pop),
    .head_o       (q_head),
    .count_o      (q_count)
  );

  always_comb begin
    we_d   = 1'b0;
    reg_d  = reg_q;
    data_d = data_q;
    if (pipe_sel) begin
      we_d   = 1'b1;
      reg_d  = pipe_rd;
      data_d = pipe_data;
    end else if (q_pop) begin
      we_d   = 1'b1;
      reg_d  = q_head.rd;
      data_d = q_head.data;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      we_q   <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      reg_q  <= reg_d;
      data_q <= data_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = reg_q;
  assign data_writeReg    = data_q;

`ifdef WB_ARBITER_BYPASS_EN
  // Forward the value being written this cycle; r0 is never forwarded.
  assign byp_hit_a = we_q && (byp_rs_a == reg_q) && (byp_rs_a != '0);
  assign byp_hit_b = we_q && (byp_rs_b == reg_q) && (byp_rs_b != '0);
  assign byp_data  = data_q;
`endif

endmodule : wb_arbiter
`default_nettype wire
